ecc_pm_seq: RTL and testbench

//  Parametrised scalar-multiplication sequencer for the GF(2^m) ECC multi-core processor.
//  - Sits between the host and the core cluster.
//  - Registers the host request and scans the scalar for its leading one.
//  - Issues one Montgomery-ladder step per remaining key bit to the cores.
//  - Requests affine conversion, then captures and holds the result with done/err status.

---
 rtl/ecc_pkg.sv | 27 ++
 rtl/ecc_wdog_cnt.sv | 38 +++
 rtl/ecc_pm_seq.sv | 177 +++++++++++++++++
 tb/tb_ecc_pm_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared defaults, width helpers and FSM encoding for the GF(2^m) scalar-multiplication sequencer.
package ecc_pkg;

    localparam int FIELD_W_DEF     = 163;
    localparam int TIMEOUT_CYC_DEF = 65535;

    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic int wdog_w(input int t);
        return $clog2(t + 1);
    endfunction

    localparam int IDX_W  = idx_w(FIELD_W_DEF);
    localparam int WDOG_W = wdog_w(TIMEOUT_CYC_DEF);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        INIT = 3'd2,
        STEP = 3'd3,
        CONV = 3'd4,
        DONE = 3'd5
    } pm_state_e;

endpackage

// File: rtl/ecc_wdog_cnt.sv
// Request watchdog: counts cycles a core request waits; expired fires on the cycle the
// count would reach TIMEOUT_CYC, so a request is held for exactly TIMEOUT_CYC cycles.
module ecc_wdog_cnt
    import ecc_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int W           = wdog_w(TIMEOUT_CYC)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of clr: clr is derived from the FSM next state, which consumes expired.
    assign expired = inc && (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ecc_pm_seq.sv
// Montgomery-ladder scalar-multiplication sequencer between host and ECC core cluster.
// Build option ECC_ZERO_SCALAR_INF_EN: zero scalar reports inf instead of err.
module ecc_pm_seq
    import ecc_pkg::*;
#(
    parameter int FIELD_W     = FIELD_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [FIELD_W-1:0] din,
    output logic [FIELD_W-1:0] dx,
    output logic [FIELD_W-1:0] dy,
    output logic               done,
    output logic               busy,
    output logic               err,
`ifdef ECC_ZERO_SCALAR_INF_EN
    output logic               inf,
`endif
    output logic               cores_en,
    output logic               key_bit,
    output logic               step_req,
    input  logic               step_ack,
    output logic               conv_req,
    input  logic               conv_ack,
    input  logic [FIELD_W-1:0] eng_x,
    input  logic [FIELD_W-1:0] eng_y
);

    localparam int            IW      = idx_w(FIELD_W);
    localparam logic [IW-1:0] IDX_MSB = IW'(FIELD_W - 1);

    pm_state_e          state_q, state_d;
    logic               reg_enable_q;
    logic [FIELD_W-1:0] reg_din_q;
    logic [FIELD_W-1:0] k_q, k_d;
    logic [FIELD_W-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               err_q, err_d;
`ifdef ECC_ZERO_SCALAR_INF_EN
    logic               inf_q, inf_d;
`endif
    logic               wdog_clr, wdog_inc, wdog_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
`ifdef ECC_ZERO_SCALAR_INF_EN
        inf_d   = inf_q;
`endif
        case (state_q)
            IDLE: if (reg_enable_q) begin
                k_d     = reg_din_q;
                idx_d   = IDX_MSB;
                err_d   = 1'b0;
`ifdef ECC_ZERO_SCALAR_INF_EN
                inf_d   = 1'b0;
`endif
                state_d = SCAN;
            end
            SCAN: if (k_q[idx_q]) begin
                state_d = INIT;
            end else if (idx_q == '0) begin
                dx_d    = '0;
                dy_d    = '0;
`ifdef ECC_ZERO_SCALAR_INF_EN
                inf_d   = 1'b1;
`else
                err_d   = 1'b1;
`endif
                state_d = DONE;
            end else begin
                idx_d = idx_q - 1'b1;
            end
            // idx_q holds the leading-one position p here.
            INIT: if (idx_q == '0) begin
                state_d = CONV;
            end else begin
                idx_d   = idx_q - 1'b1;
                state_d = STEP;
            end
            STEP: if (step_ack) begin
                if (idx_q == '0) begin
                    state_d = CONV;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end else if (wdog_expired) begin
                dx_d    = '0;
                dy_d    = '0;
                err_d   = 1'b1;
                state_d = DONE;
            end
            CONV: if (conv_ack) begin
                dx_d    = eng_x;
                dy_d    = eng_y;
                state_d = DONE;
            end else if (wdog_expired) begin
                dx_d    = '0;
                dy_d    = '0;
                err_d   = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        cores_en = (state_q == INIT);
        step_req = (state_q == STEP);
        conv_req = (state_q == CONV);
        key_bit  = (state_q == STEP) && k_q[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_enable_q <= 1'b0;
            reg_din_q    <= '0;
            k_q          <= '0;
            idx_q        <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            err_q        <= 1'b0;
`ifdef ECC_ZERO_SCALAR_INF_EN
            inf_q        <= 1'b0;
`endif
        end else begin
            reg_enable_q <= enable;
            reg_din_q    <= din;
            k_q          <= k_d;
            idx_q        <= idx_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            err_q        <= err_d;
`ifdef ECC_ZERO_SCALAR_INF_EN
            inf_q        <= inf_d;
`endif
        end
    end

    assign wdog_clr = (state_d != state_q) || (step_req && step_ack);
    assign wdog_inc = (step_req && !step_ack) || (conv_req && !conv_ack);

    ecc_wdog_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wdog_clr),
        .inc    (wdog_inc),
        .expired(wdog_expired)
    );

    assign dx  = dx_q;
    assign dy  = dy_q;
    assign err = err_q;
`ifdef ECC_ZERO_SCALAR_INF_EN
    assign inf = inf_q;
`endif

endmodule

// File: tb/tb_ecc_pm_seq.sv
// Directed bench for ecc_pm_seq (FIELD_W=8, TIMEOUT_CYC=16) with a core model acking after 3 cycles.
module tb_ecc_pm_seq;

    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [FW-1:0] din = '0;
    logic [FW-1:0] dx, dy;
    logic          done, busy, err;
`ifdef ECC_ZERO_SCALAR_INF_EN
    logic          inf;
`endif
    logic          cores_en, key_bit, step_req, conv_req;
    logic          step_ack = 1'b0;
    logic          conv_ack = 1'b0;
    logic [FW-1:0] eng_x = '0;
    logic [FW-1:0] eng_y = '0;

    int   vec_cnt = 0;
    int   miss_cnt = 0;
    bit   step_ack_en = 1'b1;
    int   step_wait = 0;
    int   conv_wait = 0;
    int   cyc = 0;
    int   cen_cnt, done_cnt, xfer_cnt, sreq_cyc, scan_cnt, last_done_cyc, done_gap;
    logic [7:0] kb_vec;

    ecc_pm_seq #(
        .FIELD_W    (FW),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .din     (din),
        .dx      (dx),
        .dy      (dy),
        .done    (done),
        .busy    (busy),
        .err     (err),
`ifdef ECC_ZERO_SCALAR_INF_EN
        .inf     (inf),
`endif
        .cores_en(cores_en),
        .key_bit (key_bit),
        .step_req(step_req),
        .step_ack(step_ack),
        .conv_req(conv_req),
        .conv_ack(conv_ack),
        .eng_x   (eng_x),
        .eng_y   (eng_y)
    );

    always #5 clk = ~clk;

    // Core cluster model: one-cycle ack on the third cycle a request is seen.
    always @(posedge clk) begin
        #1;
        if (step_ack) begin
            step_ack = 1'b0;
        end else if (step_req && step_ack_en) begin
            step_wait++;
            if (step_wait == 3) begin
                step_ack  = 1'b1;
                step_wait = 0;
            end
        end else begin
            step_wait = 0;
        end
        if (conv_ack) begin
            conv_ack = 1'b0;
        end else if (conv_req) begin
            conv_wait++;
            if (conv_wait == 3) begin
                conv_ack  = 1'b1;
                conv_wait = 0;
            end
        end else begin
            conv_wait = 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (busy && cen_cnt == 0 && !cores_en && !done) scan_cnt++;
        if (cores_en) cen_cnt++;
        if (step_req) sreq_cyc++;
        if (step_req && step_ack) begin
            xfer_cnt++;
            kb_vec = {kb_vec[6:0], key_bit};
        end
        if (done) begin
            done_cnt++;
            done_gap      = cyc - last_done_cyc;
            last_done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counters();
        cen_cnt  = 0;
        done_cnt = 0;
        xfer_cnt = 0;
        sreq_cyc = 0;
        scan_cnt = 0;
        kb_vec   = '0;
    endtask

    task automatic launch(input logic [FW-1:0] k);
        @(posedge clk);
        #1;
        din    = k;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
        #1;
    endtask

    task automatic wait_step();
        int n = 0;
        while (!step_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("step_timeout", {31'd0, step_req}, 32'd1);
    endtask

    task automatic run_job(input logic [FW-1:0] k, input logic [FW-1:0] ex, input logic [FW-1:0] ey);
        eng_x = ex;
        eng_y = ey;
        clear_counters();
        launch(k);
        wait_done();
        $display("job din=%02h dx=%02h dy=%02h err=%0d steps=%0d cores_en=%0d scan=%0d",
                 k, dx, dy, err, xfer_cnt, cen_cnt, scan_cnt);
    endtask

    initial begin
        clear_counters();
        last_done_cyc = 0;
        done_gap      = 0;
        #2 rst = 1'b1;
        #3;
        check("rst_dx", {24'd0, dx}, 32'd0);
        check("rst_dy", {24'd0, dy}, 32'd0);
        check("rst_outs", {25'd0, done, busy, err, cores_en, key_bit, step_req, conv_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: leading one at bit 0 -> full scan, no ladder steps
        run_job(8'h01, 8'h3C, 8'hC3);
        check("j1_scan", scan_cnt, 32'd8);
        check("j1_cores_en", cen_cnt, 32'd1);
        check("j1_steps", xfer_cnt, 32'd0);
        check("j1_dx", {24'd0, dx}, 32'h3C);
        check("j1_dy", {24'd0, dy}, 32'hC3);
        check("j1_err", {31'd0, err}, 32'd0);
        check("j1_done", done_cnt, 32'd1);

        // 2: A5 -> p=7, ladder bits 6..0 = 0100101
        run_job(8'hA5, 8'h5A, 8'h96);
        check("j2_scan", scan_cnt, 32'd1);
        check("j2_steps", xfer_cnt, 32'd7);
        check("j2_keybits", {25'd0, kb_vec[6:0]}, 32'h25);
        check("j2_dx", {24'd0, dx}, 32'h5A);
        check("j2_err", {31'd0, err}, 32'd0);

        // 4: steps never acked -> watchdog abort after 16 waiting cycles
        step_ack_en = 1'b0;
        run_job(8'h80, 8'h11, 8'h22);
        check("j4_sreq_cycles", sreq_cyc, 32'd16);
        check("j4_steps", xfer_cnt, 32'd0);
        check("j4_err", {31'd0, err}, 32'd1);
        check("j4_dxdy", {16'd0, dx, dy}, 32'd0);
        check("j4_step_req", {31'd0, step_req}, 32'd0);
        step_ack_en = 1'b1;
        run_job(8'h01, 8'h77, 8'h88);
        check("j4b_err", {31'd0, err}, 32'd0);
        check("j4b_dx", {24'd0, dx}, 32'h77);

        // 3: zero scalar
        run_job(8'h00, 8'h99, 8'h66);
        check("j3_scan", scan_cnt, 32'd8);
        check("j3_cores_en", cen_cnt, 32'd0);
        check("j3_dxdy", {16'd0, dx, dy}, 32'd0);
`ifdef ECC_ZERO_SCALAR_INF_EN
        check("j3_inf", {31'd0, inf}, 32'd1);
        check("j3_err", {31'd0, err}, 32'd0);
`else
        check("j3_err", {31'd0, err}, 32'd1);
`endif

        // 5a: enable pulse while stepping is dropped
        eng_x = 8'h42;
        eng_y = 8'h24;
        clear_counters();
        launch(8'hA5);
        wait_step();
        launch(8'h01);
        wait_done();
        check("j5_err", {31'd0, err}, 32'd0);
`ifdef ECC_ZERO_SCALAR_INF_EN
        check("j5_inf", {31'd0, inf}, 32'd0);
`endif
        repeat (30) @(negedge clk);
        #1;
        check("j5_one_done", done_cnt, 32'd1);
        check("j5_idle", {31'd0, busy}, 32'd0);
        $display("job din=a5 with enable pulse mid-step: dones=%0d", done_cnt);

        // 5b: enable held -> back-to-back jobs with one IDLE cycle between
        clear_counters();
        @(posedge clk);
        #1;
        din    = 8'h01;
        enable = 1'b1;
        begin
            int n = 0;
            while (done_cnt < 2 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("j5b_dones", done_cnt, 32'd3);
        check("j5b_gap", done_gap, 32'd14);
        check("j5b_idle", {31'd0, busy}, 32'd0);
        $display("enable held: dones=%0d gap=%0d", done_cnt, done_gap);

        // 6: async reset mid-step
        clear_counters();
        launch(8'hA5);
        wait_step();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("j6_step_req", {31'd0, step_req}, 32'd0);
        check("j6_busy", {31'd0, busy}, 32'd0);
        check("j6_dxdy", {16'd0, dx, dy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_job(8'h01, 8'hE1, 8'h1E);
        check("j6b_dx", {24'd0, dx}, 32'hE1);
        check("j6b_dy", {24'd0, dy}, 32'h1E);
        check("j6b_err", {31'd0, err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
